// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Counter must hold the value DATA_WIDTH itself, hence +1.
  function automatic int cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/sequential_divider_div_step.sv
// One restoring division step: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] rem_in,
  input  logic                  dividend_bit,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_out,
  output logic                  quotient_bit
);

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH:0]   rem_full;
  logic                  borrow;
  logic                  unused_rem_msb;

  // Trial subtraction is one bit wider than the operands plus a borrow bit,
  // so the shifted-out MSB of the remainder is never lost.
  always_comb begin
    shifted        = {rem_in, dividend_bit};
    {borrow, diff} = {1'b0, shifted} - {2'b00, divisor};
    quotient_bit   = ~borrow;
    rem_full       = quotient_bit ? diff : shifted;
    rem_out        = rem_full[DATA_WIDTH-1:0];
  end

  // Remainder is always below divisor, so the top bit is provably zero.
  assign unused_rem_msb = rem_full[DATA_WIDTH];

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first.
module sequential_divider
  import divider_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  localparam int CW = cnt_width(DATA_WIDTH);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] dvd_q;
  logic [DATA_WIDTH-1:0] dvs_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] step_rem;
  logic                  step_qbit;

  div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .rem_in      (rem_q),
    .dividend_bit(dvd_q[DATA_WIDTH-1]),
    .divisor     (dvs_q),
    .rem_out     (step_rem),
    .quotient_bit(step_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (divisor == '0) ? DONE : RUN;
      RUN:  if (cnt_q == '0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else if (start) begin
            cnt_q <= CW'(DATA_WIDTH);
            dvd_q <= dividend;
            dvs_q <= divisor;
            rem_q <= '0;
            quo_q <= '0;
          end
        end
        RUN: begin
          // Counter reaching zero costs one extra cycle that only publishes results.
          if (cnt_q == '0) begin
            quotient    <= quo_q;
            remainder   <= rem_q;
            div_by_zero <= 1'b0;
          end else begin
            rem_q <= step_rem;
            dvd_q <= dvd_q << 1;
            quo_q <= {quo_q[DATA_WIDTH-2:0], step_qbit};
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// Directed self-checking bench for sequential_divider at DATA_WIDTH=4.
module tb_sequential_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient, remainder;

  int total = 0;
  int bad = 0;

  sequential_divider #(.DATA_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one division and return edges after the accepting edge until done
  // (-1 on timeout) and how many in-flight samples saw busy low.
  task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                         output int lat, output int busy_low);
    lat = -1;
    busy_low = 0;
    @(negedge clk);
    for (int i = 0; i < 30 && busy; i++) @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (!busy) busy_low++;
    if (done) lat = 0;
    else begin
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk);
        #1;
        if (!busy) busy_low++;
        if (done) begin
          lat = i;
          break;
        end
      end
    end
  endtask

  int lat, blow, npulse;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;

    // 13/3: done five edges after accept, busy throughout
    run_div(4'd13, 4'd3, lat, blow);
    check("13_3_lat", lat, 5);
    check("13_3_busy", blow, 0);
    check("13_3_q", quotient, 4);
    check("13_3_r", remainder, 1);
    check("13_3_dbz", div_by_zero, 0);
    @(posedge clk); #1;
    check("13_3_done_pulse", done, 0);
    check("13_3_idle_busy", busy, 0);
    check("13_3_hold_q", quotient, 4);

    // 9/0: immediate done with div_by_zero
    run_div(4'd9, 4'd0, lat, blow);
    check("9_0_lat", lat, 0);
    check("9_0_q", quotient, 15);
    check("9_0_r", remainder, 9);
    check("9_0_dbz", div_by_zero, 1);

    // 8/2 clears div_by_zero; start during the done cycle is ignored
    run_div(4'd8, 4'd2, lat, blow);
    check("8_2_lat", lat, 5);
    check("8_2_q", quotient, 4);
    check("8_2_r", remainder, 0);
    check("8_2_dbz", div_by_zero, 0);
    dividend = 4'd3;
    divisor  = 4'd1;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_in_done_busy", busy, 0);
    check("start_in_done_q", quotient, 4);

    // 15/1 with 6/2 requested on the following three cycles
    @(negedge clk);
    dividend = 4'd15;
    divisor  = 4'd1;
    start    = 1'b1;
    @(posedge clk); #1;
    dividend = 4'd6;
    divisor  = 4'd2;
    npulse = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        npulse++;
        check("busy_ign_q", quotient, 15);
        check("busy_ign_r", remainder, 0);
      end
    end
    check("busy_ign_pulses", npulse, 1);
    check("busy_ign_idle", busy, 0);

    // Reset two cycles into 14/5
    @(negedge clk);
    dividend = 4'd14;
    divisor  = 4'd5;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_q", quotient, 0);
    check("midrst_r", remainder, 0);
    check("midrst_dbz", div_by_zero, 0);
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) npulse++;
      if (i == 2) rst_n = 1'b1;
    end
    check("midrst_no_done", npulse, 0);
    run_div(4'd14, 4'd5, lat, blow);
    check("14_5_lat", lat, 5);
    check("14_5_q", quotient, 2);
    check("14_5_r", remainder, 4);

    // Boundaries
    run_div(4'd0, 4'd7, lat, blow);
    check("0_7_qr", {quotient, remainder}, {4'd0, 4'd0});
    run_div(4'd15, 4'd15, lat, blow);
    check("15_15_qr", {quotient, remainder}, {4'd1, 4'd0});
    run_div(4'd7, 4'd8, lat, blow);
    check("7_8_qr", {quotient, remainder}, {4'd0, 4'd7});

    // Full sweep of non-zero divisors
    for (int i = 0; i < 16; i++) begin
      for (int j = 1; j < 16; j++) begin
        logic [3:0] a, b, eq, er;
        a  = 4'(i);
        b  = 4'(j);
        eq = 4'(i / j);
        er = 4'(i % j);
        run_div(a, b, lat, blow);
        check($sformatf("sweep_%0d_%0d", i, j),
              {lat[7:0], quotient, remainder, 3'b000, div_by_zero},
              {8'd5, eq, er, 4'd0});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sequential_divider.md
SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 Parameter DATA_WIDTH, default 4; operand and result width in bits, legal range 2..32.
REQ-002 clk  input  1  Single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous assert, active-low.
REQ-004 start  input  1  Request a division; sampled only in IDLE.
REQ-005 dividend  input  DATA_WIDTH  Unsigned numerator; sampled on the accepting edge.
REQ-006 divisor  input  DATA_WIDTH  Unsigned denominator; sampled on the accepting edge.
REQ-007 busy  output  1  High while an accepted division is in progress.
REQ-008 done  output  1  One-cycle pulse; results valid.
REQ-009 quotient  output  DATA_WIDTH  Unsigned floor(dividend/divisor).
REQ-010 remainder  output  DATA_WIDTH  Unsigned dividend mod divisor.
REQ-011 div_by_zero  output  1  Set with done when divisor was 0.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 IDLE->RUN when start=1 and divisor!=0: operands registered, iteration counter loaded with DATA_WIDTH, partial remainder cleared, busy=1.
REQ-014 IDLE->DONE when start=1 and divisor=0: quotient=all ones, remainder=dividend, div_by_zero=1, no iteration.
REQ-015 RUN SHALL perform one restoring step per cycle, MSB first: shift {rem,dividend-bit}; subtract divisor if rem>=divisor; set the quotient bit accordingly.
REQ-016 The trial subtraction SHALL be DATA_WIDTH+1 bits wide, so no carry is lost when DATA_WIDTH is at its maximum.
REQ-017 RUN->DONE after exactly DATA_WIDTH steps, counter decrementing to 0.
REQ-018 DONE->IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-019 Latency: done SHALL be high during the cycle after the (DATA_WIDTH+1)th rising edge counted from the accepting edge; for div-by-zero, after the 1st edge.
REQ-020 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-021 start while busy=1 SHALL be ignored, with no effect on state, operands or results.
REQ-022 start=1 in the cycle done=1 SHALL be ignored; a new request is accepted only in IDLE.
REQ-023 quotient, remainder and div_by_zero SHALL update only on entry to DONE and SHALL hold until the next DONE entry.
REQ-024 div_by_zero SHALL be cleared when a non-zero-divisor division reaches DONE.
REQ-025 Input changes after the accepting edge SHALL NOT affect the result.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, and busy, done, div_by_zero, quotient, remainder, counter and working registers to 0.
REQ-027 Reset mid-RUN SHALL abort the operation with no done pulse; the first request after release SHALL complete normally.
REQ-028 Release of rst_n is synchronised externally; the block SHALL accept start on the first edge after release.

Structure
REQ-029 Package divider_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and a localparam function computing the counter width, $clog2(DATA_WIDTH+1).
REQ-030 One combinational sub-module div_step (inputs: partial remainder, next dividend bit, divisor; outputs: new remainder, quotient bit) SHALL implement REQ-015 and REQ-016.
REQ-031 No multipliers and no combinational "/" or "%" operators SHALL be used.

Verification
REQ-032 Exhaustive sweep, DATA_WIDTH=4, all 16x16 pairs with divisor!=0 -> quotient=i/j and remainder=i%j, div_by_zero=0; bench prints OK/Error per case and a PASSED/FAILED summary.
REQ-033 13/3 pulsed at edge k -> done high after edge k+5, quotient=4, remainder=1, busy high for cycles k+1..k+5.
REQ-034 9/0 -> done after 1 edge, quotient=15, remainder=9, div_by_zero=1; then 8/2 -> quotient=4, remainder=0, div_by_zero=0.
REQ-035 Start 15/1, then start=1 with 6/2 on each of the following 3 cycles -> single done, quotient=15, remainder=0; 6/2 not executed.
REQ-036 Start 14/5, assert rst_n=0 two cycles later -> all outputs 0 at once and no done pulse; after release, 14/5 -> quotient=2, remainder=4.
REQ-037 Boundaries 0/7 -> quotient=0, remainder=0; 15/15 -> quotient=1, remainder=0; 7/8 -> quotient=0, remainder=7.
